byte_pack_stream_fifo: RTL
==========================

// Module: byte_pack_stream_fifo
// PURPOSE
//  Successor to the compressor return-path packer. Takes a variable number of bytes per cycle
//  from the compressor output stage and repacks them into fixed-width AXI-Stream beats.
//  Adds over the previous generation:
//   - proper ready/valid output handshake;
//   - end-of-stream flush with partial-beat tkeep and tlast;
//   - exact full/empty accounting.
//  Sits between the compressor core and the AXI-Stream master DMA port.
// PARAMETERS
//  IN_BYTES     16  max bytes offered per cycle on in_data
//  OUT_BYTES     8  bytes per output beat
//  DEPTH_BYTES  64  byte storage; power of 2, >= IN_BYTES+OUT_BYTES
//  LVL_W        $clog2(DEPTH_BYTES)+1  width of level (derived, not overridden)
// PORTS
//  clk         in   1             clock, all state on rising edge
//  reset       in   1             asynchronous, active-high reset
//  in_data     in   IN_BYTES*8    offered bytes; lane 0 (bits 7:0) is the oldest byte
//  in_count    in   $clog2(IN_BYTES)+1  number of valid low lanes offered, 0..IN_BYTES
//  in_last     in   1             offered bytes end the stream (may be used with in_count=0)
//  in_accept   out  1             combinational; offer consumed at this edge, sender shifts
//  out_data    out  OUT_BYTES*8   output beat; lane 0 is the oldest byte
//  out_keep    out  OUT_BYTES     byte enables, always contiguous from bit 0
//  out_last    out  1             final beat of the stream
//  out_valid   out  1             beat present
//  out_ready   in   1             downstream accepts beat
//  level       out  LVL_W         bytes held in storage (excludes the output register)
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - clears wr_ptr, rd_ptr, level, and the state (to RUN);
//    - clears out_valid, out_last, out_keep and out_data to 0;
//    - storage RAM is not cleared.
//  - offer = (in_count!=0) || in_last.
//  - in_accept = offer && state==RUN && (DEPTH_BYTES-level >= in_count).
//  - Space is judged on the current level; a same-cycle drain is not credited (conservative).
//  - Offers are never partially accepted: all in_count bytes or none.
//  - On accept: byte i is written to mem[(wr_ptr+i) mod DEPTH_BYTES] for i<in_count,
//    then wr_ptr += in_count (wraps naturally).
//  - Output register load when (!out_valid || out_ready) and either:
//    a) level >= OUT_BYTES:
//       - loads OUT_BYTES bytes, keep = all ones;
//       - out_last = 1 only if state==FLUSH and level==OUT_BYTES.
//    b) state==FLUSH and level < OUT_BYTES:
//       - loads level bytes;
//       - keep = (1<<level)-1, unused lanes 0, out_last = 1;
//       - level==0 yields a null beat, keep=0, last=1.
//  - Otherwise, when out_ready && out_valid, clear out_valid.
//  - A load sets out_valid=1 and advances rd_ptr by the bytes loaded.
//  - While out_valid && !out_ready: out_data, out_keep and out_last are held stable.
//  - level_next = level + (accept ? in_count : 0) - (load ? bytes_loaded : 0).
//    Simultaneous accept+load are both applied; level never exceeds DEPTH_BYTES.
//  - Latency: a byte accepted at edge N is visible on out_data no earlier than after edge N+1.
//  - FSM:
//    - RUN -> FLUSH when an offer with in_last=1 is accepted.
//    - FLUSH -> RUN at the edge that loads the out_last=1 beat.
//    - In FLUSH, in_accept=0, so the next stream stalls until the flush beat is loaded.
//  - out_last is asserted on exactly one beat per stream.
//  - No byte of a stream is emitted after its out_last beat.
// TESTING (IN=16, OUT=8, DEPTH=64 unless noted)
//  1. Partial final beat, out_ready=1: offer in_count=5 three times (bytes 0..14), then
//     in_last with in_count=0 -> beat 0..7 keep=8'hFF last=0, then beat 8..14
//     keep=8'h7F last=1.
//  2. Backpressure: out_ready=0, offer in_count=16 every cycle.
//     -> in_accept high 4 cycles, then low with level=56; out_data frozen (bytes 0..7).
//     Raise out_ready -> all 64 bytes emitted in order, no loss or duplication.
//  3. Wrap: 200 incrementing bytes, random in_count 0..16, random out_ready, in_last on
//     final offer -> byte sequence identical; 25 beats; last beat keep=8'hFF last=1;
//     level returns to 0.
//  4. Empty stream: idle, offer in_last=1 with in_count=0 -> one beat keep=0 last=1;
//     state back to RUN.
//  5. Reset mid-operation: assert reset with out_valid=1, level=20.
//     -> out_valid=0 and level=0 immediately (async).
//     After release, a new 8-byte stream emits only the new bytes, keep=8'hFF last=1.
//  6. No partial accept: level=56, offer in_count=16 with in_last -> in_accept=0 until
//     level<=48, then the offer is accepted whole and the flush produces a correct
//     tkeep/tlast.

Source files
------------

// File: rtl/byte_pack_stream_fifo.sv
// ---------------------------------------------------------------------------
// byte_pack_stream_fifo
//
// Repacks a variable number of bytes per cycle (0..IN_BYTES) coming from the
// compressor output stage into fixed-width AXI-Stream style beats of
// OUT_BYTES bytes. Bytes are stored in a circular byte buffer and drained
// into a registered output beat with a ready/valid handshake. An offer with
// in_last set closes the stream: the remaining bytes are flushed as a final
// beat, which may be partial (contiguous keep) or even empty (keep=0), and
// that beat carries out_last.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   in_data    offered bytes, lane 0 (bits 7:0) is the oldest
//   in_count   number of valid low lanes in in_data (0..IN_BYTES)
//   in_last    offered bytes end the stream (legal with in_count=0)
//   in_accept  combinational: the offer is consumed at this clock edge
//   out_data   output beat, lane 0 is the oldest byte
//   out_keep   byte enables, contiguous from bit 0
//   out_last   final beat of the stream
//   out_valid  beat present
//   out_ready  downstream accepts the beat
//   level      bytes held in storage (not counting the output register)
// ---------------------------------------------------------------------------
module byte_pack_stream_fifo #(
    parameter int  IN_BYTES    = 16,
    parameter int  OUT_BYTES   = 8,
    parameter int  DEPTH_BYTES = 64,
    localparam int LVL_W       = $clog2(DEPTH_BYTES) + 1,
    localparam int CNT_W       = $clog2(IN_BYTES) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IN_BYTES*8-1:0]  in_data,
    input  logic [CNT_W-1:0]       in_count,
    input  logic                   in_last,
    output logic                   in_accept,
    output logic [OUT_BYTES*8-1:0] out_data,
    output logic [OUT_BYTES-1:0]   out_keep,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LVL_W-1:0]       level
);

    localparam int PTR_W = $clog2(DEPTH_BYTES);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Byte storage; not reset, contents are only ever read below level.
    logic [7:0]             mem [DEPTH_BYTES];

    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [LVL_W-1:0]       level_reg;
    logic [LVL_W-1:0]       level_next;
    state_t                 state_reg;
    state_t                 state_next;

    logic [OUT_BYTES*8-1:0] out_data_reg;
    logic [OUT_BYTES-1:0]   out_keep_reg;
    logic                   out_last_reg;
    logic                   out_valid_reg;

    logic                   offer;
    logic [LVL_W-1:0]       space;
    logic                   can_load;
    logic                   load_full;
    logic                   load_partial;
    logic                   load;
    logic                   load_last;
    logic [LVL_W-1:0]       load_bytes;
    logic [OUT_BYTES*8-1:0] lane_data;
    logic [OUT_BYTES-1:0]   lane_valid;

    // ------------------------------------------------------------------
    // Input side. Space is judged on the current level only; a drain in
    // the same cycle is not credited, so the check is conservative.
    // Offers are taken whole or not at all.
    // ------------------------------------------------------------------
    assign offer     = (in_count != '0) || in_last;
    assign space     = LVL_W'(DEPTH_BYTES) - level_reg;
    assign in_accept = offer && (state_reg == RUN) && (space >= LVL_W'(in_count));

    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_BYTES; i++) begin
            if (in_accept && (CNT_W'(i) < in_count)) begin
                mem[wr_ptr_reg + PTR_W'(i)] <= in_data[i*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output side. A full beat is loaded whenever enough bytes are stored;
    // in FLUSH with fewer than a beat left, the remainder (possibly zero
    // bytes) goes out as the final beat. Bytes written this cycle are not
    // yet counted in level, so the read lanes never alias a write.
    // ------------------------------------------------------------------
    assign can_load     = !out_valid_reg || out_ready;
    assign load_full    = level_reg >= LVL_W'(OUT_BYTES);
    assign load_partial = (state_reg == FLUSH) && !load_full;
    assign load         = can_load && (load_full || load_partial);
    assign load_bytes   = load_full ? LVL_W'(OUT_BYTES) : level_reg;
    // The beat that empties storage during FLUSH is the last one.
    assign load_last    = (state_reg == FLUSH) && (level_reg <= LVL_W'(OUT_BYTES));

    generate
        for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_lane
            logic [PTR_W-1:0] rd_addr;
            assign rd_addr                = rd_ptr_reg + PTR_W'(gi);
            assign lane_valid[gi]         = LVL_W'(gi) < load_bytes;
            assign lane_data[gi*8 +: 8]   = lane_valid[gi] ? mem[rd_addr] : 8'h00;
        end
    endgenerate

    always_comb begin
        level_next = level_reg;
        if (in_accept) begin
            level_next = level_next + LVL_W'(in_count);
        end
        if (load) begin
            level_next = level_next - load_bytes;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (in_accept && in_last) state_next = FLUSH;
            FLUSH:   if (load && load_last)    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            state_reg     <= RUN;
            out_data_reg  <= '0;
            out_keep_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            level_reg <= level_next;
            state_reg <= state_next;
            if (in_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(in_count);
            end
            if (load) begin
                rd_ptr_reg    <= rd_ptr_reg + PTR_W'(load_bytes);
                out_data_reg  <= lane_data;
                out_keep_reg  <= lane_valid;
                out_last_reg  <= load_last;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_keep  = out_keep_reg;
    assign out_last  = out_last_reg;
    assign out_valid = out_valid_reg;
    assign level     = level_reg;

endmodule
